pc_stack_counter: RTL and testbench
===================================

Name: pc_stack_counter

Overview:
- Parametrised program counter for the down-sampler control processor. It supersedes the fixed 16-bit load/increment counter.
- Adds:
  - configurable address width and reset vector
  - relative branch
  - stall
  - call/return via an internal return-address LIFO, with full/empty/error status
- Drives the instruction-memory and operand-fetch address buses; the three address outputs are kept for drop-in wiring.

Parameters:
- ADDR_W, 16, width of PC and all address ports
- STACK_DEPTH, 4, return-address stack entries (≥1)
- RESET_VEC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze PC and stack this cycle
- en  in  1  absolute load from c_in
- incr_en  in  1  increment PC
- branch_en  in  1  relative branch: PC + offset
- call_en  in  1  push PC+1, then PC <= c_in
- ret_en  in  1  pop top-of-stack into PC
- err_clr  in  1  clear sticky stack_err
- c_in  in  ADDR_W  absolute target
- offset  in  ADDR_W  two's-complement branch displacement
- a_out  out  ADDR_W  current PC (operand A address)
- b_out  out  ADDR_W  current PC (operand B address)
- im_out  out  ADDR_W  current PC (instruction address)
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_empty  out  1  stack holds 0 entries
- stack_err  out  1  sticky: overflow/underflow attempted

Behaviour:
- Reset (async, immediate):
  - PC = RESET_VEC; stack pointer = 0; stack contents don't-care
  - stack_empty=1, stack_full=0, stack_err=0
- Outputs:
  - a_out/b_out/im_out are identical, registered copies of PC.
  - Status outputs decode from the registered pointer. No combinational path from controls to outputs.
- Update occurs on the rising clk edge. The priority is fixed and exactly one action is taken:
  1. stall=1: hold everything. err_clr is still honoured.
  2. ret_en:
     - if not empty: PC <= top, pointer−1
     - if empty: PC holds, stack_err <= 1
  3. call_en:
     - if not full: mem[ptr] <= PC+1, pointer+1, PC <= c_in
     - if full: PC holds, no push, stack_err <= 1
  4. en:
     - en & incr_en: PC <= c_in+1 (legacy load-then-increment semantics, retained)
     - en alone: PC <= c_in
  5. branch_en: PC <= PC + offset.
     - incr_en is ignored when branch_en=1.
  6. incr_en: PC <= PC+1.
  7. none asserted: hold.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W.
  - PC=all-ones +1 wraps to 0.
  - Negative offsets wrap likewise.
  - The pushed return address PC+1 also wraps.
- stack_err:
  - set has priority over err_clr in the same cycle
  - otherwise err_clr clears it
- Pointer range is 0..STACK_DEPTH. It never exceeds either bound.
- A reset asserted mid-call/ret aborts the operation. State equals the reset values on release. The first active edge after deassertion executes normally.
- Call and ret in the same cycle: ret wins per priority. No push occurs.

Decomposition:
- Shared package pc_pkg:
  - op-priority encoding constants (OP_HOLD, OP_RET, OP_CALL, OP_LOAD, OP_BRANCH, OP_INCR)
  - pointer-width function clog2(STACK_DEPTH+1)
- Sub-module pc_ret_stack:
  - LIFO with push/pop/top/full/empty
  - parametrised by ADDR_W, STACK_DEPTH
  - same clk/rst
- Top level holds the priority decode, PC register and error flag.

Test Plan:
- Reset with PC running at 0x0042, rst pulsed mid-cycle → outputs go to RESET_VEC (0x0000) immediately, asynchronously; stack_empty=1, stack_err=0.
- Load and increment sequence:
  - en=1, c_in=0x0100 → PC=0x0100
  - then incr_en ×3 → 0x0103
  - then en=1 & incr_en=1, c_in=0x0200 → 0x0201
  - wrap check: PC=0xFFFF, incr_en → 0x0000
- Branch:
  - PC=0x0010, branch_en, offset=0xFFFC (−4) → 0x000C
  - offset=0x0008 with incr_en also high → 0x0014, incr ignored
- Nested calls, DEPTH=4:
  - from PC=0x0005: call to 0x0100, then call to 0x0200 → stack holds 0x0006, 0x0101
  - ret → PC=0x0101; ret → PC=0x0006; stack_empty=1
- Stack limits:
  - 4 calls → stack_full=1
  - 5th call → PC unchanged, stack_err=1
  - drain 4 rets, then extra ret → PC unchanged, stack_err remains 1
  - err_clr → 0
- Stall: stall=1 with call_en, en and incr_en all high for 3 cycles → PC and pointer unchanged; stall drops → the call executes.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return-address stack:
// action encoding and pointer sizing.
package pc_pkg;

    // One action per cycle, listed in decreasing priority.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_RET    = 3'd1,
        OP_CALL   = 3'd2,
        OP_LOAD   = 3'd3,
        OP_BRANCH = 3'd4,
        OP_INCR   = 3'd5
    } pc_op_e;

    // Pointer must represent 0..depth inclusive.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a physical slot index (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : pc_pkg

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push/pop with saturating pointer, top-of-stack read,
// full/empty decoded from the registered pointer.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = ptr_width(STACK_DEPTH);
    localparam int IDX_W = idx_width(STACK_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  top_ptr;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] mem [2**IDX_W];

    assign full  = (ptr_reg == DEPTH_P);
    assign empty = (ptr_reg == '0);

    // Pop wins over push; both are refused at the respective bound.
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;

    always_comb begin
        ptr_next = ptr_reg;
        if (do_pop) begin
            ptr_next = ptr_reg - ONE_P;
        end else if (do_push) begin
            ptr_next = ptr_reg + ONE_P;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[ptr_reg[IDX_W-1:0]] <= push_data;
        end
    end

    assign top_ptr = empty ? '0 : (ptr_reg - ONE_P);
    assign top     = mem[top_ptr[IDX_W-1:0]];

endmodule : pc_ret_stack

// File: rtl/pc_stack_counter.sv
// Program counter for the down-sampler control processor: absolute load,
// relative branch, increment, stall and call/return through a LIFO.
module pc_stack_counter
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              en,
    input  logic              incr_en,
    input  logic              branch_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              err_clr,
    input  logic [ADDR_W-1:0] c_in,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] a_out,
    output logic [ADDR_W-1:0] b_out,
    output logic [ADDR_W-1:0] im_out,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    pc_op_e            op;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic              err_reg;
    logic              err_next;
    logic              err_set;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;

    always_comb begin
        op = OP_HOLD;
        if (stall) begin
            op = OP_HOLD;
        end else if (ret_en) begin
            op = OP_RET;
        end else if (call_en) begin
            op = OP_CALL;
        end else if (en) begin
            op = OP_LOAD;
        end else if (branch_en) begin
            op = OP_BRANCH;
        end else if (incr_en) begin
            op = OP_INCR;
        end
    end

    assign push_data = pc_reg + ONE_A;

    always_comb begin
        pc_next = pc_reg;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (op)
            OP_RET: begin
                if (stk_empty) begin
                    err_set = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = stk_top;
                end
            end
            OP_CALL: begin
                if (stk_full) begin
                    err_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = c_in;
                end
            end
            // Legacy behaviour: load-and-increment lands on c_in+1.
            OP_LOAD:   pc_next = incr_en ? (c_in + ONE_A) : c_in;
            OP_BRANCH: pc_next = pc_reg + offset;
            OP_INCR:   pc_next = pc_reg + ONE_A;
            default:   pc_next = pc_reg;
        endcase
    end

    // A new error outranks a clear arriving in the same cycle.
    always_comb begin
        err_next = err_reg;
        if (err_set) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= RESET_VEC;
            err_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            err_reg <= err_next;
        end
    end

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign a_out       = pc_reg;
    assign b_out       = pc_reg;
    assign im_out      = pc_reg;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;
    assign stack_err   = err_reg;

endmodule : pc_stack_counter

// File: tb/tb_pc_stack_counter.sv
// Directed and randomized checks of pc_stack_counter against a queue-based
// behavioural model of the counter and its return stack.
module tb_pc_stack_counter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, en, incr_en, branch_en, call_en, ret_en, err_clr;
    logic [15:0] c_in, offset;
    logic [15:0] a_out, b_out, im_out;
    logic        stack_full, stack_empty, stack_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_err;

    pc_stack_counter #(
        .ADDR_W      (16),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .en          (en),
        .incr_en     (incr_en),
        .branch_en   (branch_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .err_clr     (err_clr),
        .c_in        (c_in),
        .offset      (offset),
        .a_out       (a_out),
        .b_out       (b_out),
        .im_out      (im_out),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    // Reference rules: one action per cycle in fixed priority order.
    task automatic model_step();
        bit set_err;
        set_err = 0;
        if (!stall) begin
            if (ret_en) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else set_err = 1;
            end else if (call_en) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back(m_pc + 16'd1);
                    m_pc = c_in;
                end else set_err = 1;
            end else if (en) begin
                m_pc = incr_en ? c_in + 16'd1 : c_in;
            end else if (branch_en) begin
                m_pc = m_pc + offset;
            end else if (incr_en) begin
                m_pc = m_pc + 16'd1;
            end
        end
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".a"}, {16'h0, a_out}, {16'h0, m_pc});
        chk({tag, ".b"}, {16'h0, b_out}, {16'h0, m_pc});
        chk({tag, ".im"}, {16'h0, im_out}, {16'h0, m_pc});
        chk({tag, ".full"}, {31'h0, stack_full}, {31'h0, (m_stk.size() == DEPTH)});
        chk({tag, ".empty"}, {31'h0, stack_empty}, {31'h0, (m_stk.size() == 0)});
        chk({tag, ".err"}, {31'h0, stack_err}, {31'h0, m_err});
    endtask

    task automatic drive(input bit s, input bit r, input bit c, input bit e, input bit i,
                         input bit b, input bit ec, input logic [15:0] ci, input logic [15:0] off);
        stall = s; ret_en = r; call_en = c; en = e; incr_en = i;
        branch_en = b; err_clr = ec; c_in = ci; offset = off;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        $display("cycle %s: pc=%h full=%b empty=%b err=%b", tag, a_out, stack_full, stack_empty, stack_err);
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        model_reset();
        #1;
        check_model("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Async reset mid-cycle with PC at 0x0042
        drive(0, 0, 0, 1, 0, 0, 0, 16'h0042, 16'h0); step("load42");
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", {16'h0, im_out}, 32'h0);
        chk("async_rst_empty", {31'h0, stack_empty}, 32'h1);
        chk("async_rst_err", {31'h0, stack_err}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Load and increment
        drive(0, 0, 0, 1, 0, 0, 0, 16'h0100, 16'h0); step("load100");
        drive(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) step("incr");
        chk("incr3", {16'h0, a_out}, 32'h0103);
        drive(0, 0, 0, 1, 1, 0, 0, 16'h0200, 16'h0); step("load_inc");
        chk("load_inc", {16'h0, a_out}, 32'h0201);
        drive(0, 0, 0, 1, 0, 0, 0, 16'hFFFF, 16'h0); step("loadFFFF");
        drive(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0); step("wrap");
        chk("wrap", {16'h0, a_out}, 32'h0000);

        // Branch
        drive(0, 0, 0, 1, 0, 0, 0, 16'h0010, 16'h0); step("load10");
        drive(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'hFFFC); step("br_neg");
        chk("br_neg", {16'h0, a_out}, 32'h000C);
        drive(0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0008); step("br_pos");
        chk("br_pos", {16'h0, a_out}, 32'h0014);

        // Nested calls
        drive(0, 0, 0, 1, 0, 0, 0, 16'h0005, 16'h0); step("load5");
        drive(0, 0, 1, 0, 0, 0, 0, 16'h0100, 16'h0); step("call1");
        drive(0, 0, 1, 0, 0, 0, 0, 16'h0200, 16'h0); step("call2");
        drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0); step("ret1");
        chk("ret1", {16'h0, a_out}, 32'h0101);
        step("ret2");
        chk("ret2", {16'h0, a_out}, 32'h0006);
        chk("ret2_empty", {31'h0, stack_empty}, 32'h1);

        // Stack limits
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 16'(k * 16), 16'h0); step("fill");
        end
        chk("full", {31'h0, stack_full}, 32'h1);
        drive(0, 0, 1, 0, 0, 0, 0, 16'h0050, 16'h0); step("overflow");
        chk("ovf_pc", {16'h0, a_out}, 32'h0040);
        chk("ovf_err", {31'h0, stack_err}, 32'h1);
        drive(0, 0, 1, 0, 0, 0, 1, 16'h0060, 16'h0); step("ovf_clr");
        chk("set_beats_clr", {31'h0, stack_err}, 32'h1);
        drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) step("drain");
        drive(0, 1, 1, 0, 0, 0, 0, 16'h0777, 16'h0); step("underflow");
        chk("udf_empty", {31'h0, stack_empty}, 32'h1);
        chk("udf_err", {31'h0, stack_err}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0); step("err_clr");
        chk("err_clr", {31'h0, stack_err}, 32'h0);

        // Stall freezes a pending call
        drive(1, 0, 1, 1, 1, 0, 0, 16'h0300, 16'h0);
        for (int k = 0; k < 3; k++) step("stall");
        drive(0, 0, 1, 1, 1, 0, 0, 16'h0300, 16'h0); step("unstall");
        chk("unstall_pc", {16'h0, a_out}, 32'h0300);
        chk("unstall_empty", {31'h0, stack_empty}, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0, 16'($urandom), 16'($urandom));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_stack_counter
